zap_wb_data_responder: RTL and testbench
========================================

ZAP_WB_DATA_RESPONDER -- requirements
Module: zap_wb_data_responder

Interface
REQ-001 Parameter DEPTH, 256: number of 32-bit memory words; a power of two, 2 to 4096.
REQ-002 Parameter WAIT_STATES, 2: wait cycles inserted before each response; 0 to 15.
REQ-003 Parameter BASE_ADDR, 32'h0: byte base address of the window; 4-byte aligned.
REQ-004 i_clk  in  1  clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 i_wb_cyc  in  1  Wishbone cycle-valid from the data-bus initiator.
REQ-007 i_wb_stb  in  1  Wishbone strobe.
REQ-008 i_wb_we  in  1  1 = write, 0 = read.
REQ-009 i_wb_adr  in  32  byte address; bits [1:0] are ignored.
REQ-010 i_wb_dat  in  32  write data.
REQ-011 i_wb_sel  in  4  byte-lane enables; bit n covers bits [8n+7:8n].
REQ-012 o_wb_ack  out  1  registered; normal termination.
REQ-013 o_wb_err  out  1  registered; error termination.
REQ-014 o_wb_dat  out  32  registered read data.
REQ-015 o_busy  out  1  registered; high while a transaction is held.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 In IDLE, a request is i_wb_cyc&i_wb_stb sampled high at edge E; the block SHALL latch adr, we, dat and sel at E.
REQ-018 At edge E the FSM SHALL go to RESP if WAIT_STATES=0, else to WAIT with counter=WAIT_STATES-1.
REQ-019 In WAIT the counter SHALL decrement by 1 per edge; at count 0 the next edge SHALL go to RESP.
REQ-020 Latency: ack or err SHALL be high for exactly the one cycle following edge E+WAIT_STATES.
REQ-021 RESP SHALL last one cycle and SHALL always return to IDLE.
REQ-022 A request still asserted during RESP SHALL NOT be resampled; it is only sampled again in IDLE, so throughput is at most one transaction per WAIT_STATES+2 cycles.
REQ-023 Decode: in range iff BASE_ADDR <= adr < BASE_ADDR+4*DEPTH; word index = (adr-BASE_ADDR)>>2.
REQ-024 In range: the RESP cycle SHALL assert o_wb_ack=1 and o_wb_err=0. Out of range: o_wb_err=1, o_wb_ack=0, and memory is not accessed.
REQ-025 An in-range write SHALL update only the bytes whose sel bit is 1, at the edge entering RESP.
REQ-026 A write with sel=4'h0 SHALL still be acked and SHALL leave memory unchanged.
REQ-027 On a read, o_wb_dat SHALL hold the addressed word during the ack cycle.
REQ-028 o_wb_dat SHALL be 0 in every other cycle, including error cycles and write acks.
REQ-029 Abort: i_wb_cyc or i_wb_stb low at any edge in WAIT SHALL return the FSM to IDLE with no ack, no err and no write.
REQ-030 o_wb_ack and o_wb_err SHALL never be high in the same cycle.
REQ-031 o_busy SHALL be 1 exactly when the state is WAIT or RESP.

Reset
REQ-032 When i_reset is asserted, without waiting for a clock edge: state=IDLE, counter=0, o_wb_ack=0, o_wb_err=0, o_wb_dat=0, o_busy=0.
REQ-033 Reset SHALL NOT initialise memory contents; they are unspecified after power-up and retained across reset.
REQ-034 A reset asserted during WAIT or RESP SHALL discard the transaction: no write is performed and no ack is given.
REQ-035 The first request SHALL be sampled on the first rising edge after i_reset deasserts.

Verification
REQ-036 WAIT_STATES=2, write 0xDEADBEEF, sel=4'hF, to 0x10 sampled at edge E: ack is high only in the cycle after E+2. A later read of 0x10 returns o_wb_dat=0xDEADBEEF with ack.
REQ-037 Then write 0x0000AA00 with sel=4'b0010 to 0x10, then read 0x10: returns 0xDEADAAEF.
REQ-038 DEPTH=256, read adr 0x400: err for one cycle, ack=0, o_wb_dat=0. Then write adr 0x400: err, and a read of 0x0 is unchanged.
REQ-039 Write 0x12345678 to 0x20, drop i_wb_cyc one cycle after E: no ack or err ever. A read of 0x20 returns the prior value.
REQ-040 i_reset pulsed between clock edges during WAIT of a write: o_busy, ack and err go to 0 immediately, and the word is unchanged.
REQ-041 cyc/stb held high across two back-to-back reads with WAIT_STATES=0: acks occur two cycles apart, one per transaction, with no ack in between.

Source files
------------

// File: rtl/zap_wb_data_responder.sv
`default_nettype none
// ============================================================================
// Module   : zap_wb_data_responder
// Brief    : Wishbone data-bus memory responder with programmable wait states
//            and address-window error termination.
// Revision : 1.0 - initial release
// ============================================================================

module zap_wb_data_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_dat,
  output logic        o_busy
);

  localparam int          c_aw     = $clog2(DEPTH);
  localparam logic [29:0] c_depth  = 30'(DEPTH);
  localparam logic [3:0]  c_ws_m1  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [31:0]     r_adr;
  logic            r_we;
  logic [31:0]     r_dat;
  logic [3:0]      r_sel;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_in_idle;
  logic [31:0]     w_adr;
  logic            w_we;
  logic [31:0]     w_dat;
  logic [3:0]      w_sel;
  logic [31:0]     w_aligned;
  logic [31:0]     w_off;
  logic            w_in_range;
  logic [c_aw-1:0] w_idx;
  logic            w_enter_resp;
  logic            w_wr_en;
  logic [31:0]     w_rd_dat;
  logic            w_unused;

  assign w_req     = i_wb_cyc & i_wb_stb;
  assign w_in_idle = (r_state == S_IDLE);

  // With zero wait states the access happens on the sampling edge itself, so
  // the live bus fields are used; otherwise the latched copies are used.
  assign w_adr = w_in_idle ? i_wb_adr : r_adr;
  assign w_we  = w_in_idle ? i_wb_we  : r_we;
  assign w_dat = w_in_idle ? i_wb_dat : r_dat;
  assign w_sel = w_in_idle ? i_wb_sel : r_sel;

  assign w_aligned  = {w_adr[31:2], 2'b00};
  assign w_off      = w_aligned - BASE_ADDR;
  assign w_in_range = (w_aligned >= BASE_ADDR) && (w_off[31:2] < c_depth);
  assign w_idx      = w_off[c_aw+1:2];

  assign w_enter_resp = w_req &&
                        ((w_in_idle && (WAIT_STATES == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == 4'd0)));
  assign w_wr_en  = w_enter_resp && w_we && w_in_range && !i_reset;
  assign w_rd_dat = (w_in_range && !w_we) ? r_mem[w_idx] : 32'h0;
  assign w_unused = &{1'b0, w_adr[1:0], w_off[1:0]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_adr    <= 32'h0;
      r_we     <= 1'b0;
      r_dat    <= 32'h0;
      r_sel    <= 4'h0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= 32'h0;
      o_busy   <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= 32'h0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_adr  <= i_wb_adr;
            r_we   <= i_wb_we;
            r_dat  <= i_wb_dat;
            r_sel  <= i_wb_sel;
            o_busy <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state  <= S_RESP;
              o_wb_ack <= w_in_range;
              o_wb_err <= !w_in_range;
              o_wb_dat <= w_rd_dat;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_ws_m1;
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            o_busy  <= 1'b0;
          end else if (r_cnt == 4'd0) begin
            r_state  <= S_RESP;
            o_wb_ack <= w_in_range;
            o_wb_err <= !w_in_range;
            o_wb_dat <= w_rd_dat;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory is deliberately left out of reset so contents survive it.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_sel[b]) r_mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zap_wb_data_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_zap_wb_data_responder
// Brief    : Directed self-checking bench for zap_wb_data_responder.
// Revision : 1.0 - initial release
// ============================================================================

module tb_zap_wb_data_responder;

  localparam int c_ws = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        ack, err, busy;
  logic [31:0] rdat;

  logic        cyc0, stb0, we0;
  logic [31:0] adr0, wdat0;
  logic [3:0]  sel0;
  logic        ack0, err0, busy0;
  logic [31:0] rdat0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  zap_wb_data_responder #(.DEPTH(256), .WAIT_STATES(c_ws), .BASE_ADDR(32'h0)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel),
    .o_wb_ack(ack), .o_wb_err(err), .o_wb_dat(rdat), .o_busy(busy)
  );

  zap_wb_data_responder #(.DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc0), .i_wb_stb(stb0), .i_wb_we(we0),
    .i_wb_adr(adr0), .i_wb_dat(wdat0), .i_wb_sel(sel0),
    .o_wb_ack(ack0), .o_wb_err(err0), .o_wb_dat(rdat0), .o_busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One full transaction on the WAIT_STATES=2 instance, checked cycle by cycle.
  task automatic txn(input string tag, input logic t_we, input logic [31:0] t_adr,
                     input logic [31:0] t_dat, input logic [3:0] t_sel,
                     input logic exp_err, input logic [31:0] exp_rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; wdat = t_dat; sel = t_sel;
    @(posedge clk);
    for (int k = 0; k <= c_ws; k++) begin
      @(negedge clk);
      if (k < c_ws) begin
        check({tag, "_wait_ackerr"}, {30'h0, ack, err}, 32'h0);
        check({tag, "_wait_busy"}, {31'h0, busy}, 32'h1);
      end else begin
        check({tag, "_resp_ack"}, {31'h0, ack}, {31'h0, !exp_err});
        check({tag, "_resp_err"}, {31'h0, err}, {31'h0, exp_err});
        check({tag, "_resp_dat"}, rdat, exp_rd);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check({tag, "_after"}, {29'h0, ack, err, busy}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0;
    cyc0 = 0; stb0 = 0; we0 = 0; adr0 = 32'h4; wdat0 = 0; sel0 = 0;
    #12;
    check("reset_outs", {29'h0, ack, err, busy}, 32'h0);
    check("reset_dat", rdat, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    txn("wr0",     1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
    txn("wr10",    1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    txn("rd10",    1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF);
    txn("wr10b",   1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010, 1'b0, 32'h0);
    txn("rd10b",   1'b0, 32'h0000_0013, 32'h0,         4'hF, 1'b0, 32'hDEAD_AAEF);
    txn("rd400",   1'b0, 32'h0000_0400, 32'h0,         4'hF, 1'b1, 32'h0);
    txn("wr400",   1'b1, 32'h0000_0400, 32'h1111_1111, 4'hF, 1'b1, 32'h0);
    txn("rd0",     1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D);
    txn("wrsel0",  1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0);
    txn("rdsel0",  1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_AAEF);
    txn("wr3fc",   1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0);
    txn("rd3fc",   1'b0, 32'h0000_03FC, 32'h0,         4'hF, 1'b0, 32'hA5A5_A5A5);
    txn("wr20",    1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF, 1'b0, 32'h0);

    // Abort: drop cyc one cycle after the sampling edge.
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h20; wdat = 32'h1234_5678; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_quiet", {29'h0, ack, err, busy}, 32'h0);
    end
    stb = 0;
    txn("rd20a",   1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b0, 32'h1111_2222);

    // Asynchronous reset mid-WAIT of a write.
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h20; wdat = 32'h5555_5555; sel = 4'hF;
    @(posedge clk);
    #2;
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1; cyc = 0; stb = 0;
    #1;
    check("rst_async", {29'h0, ack, err, busy}, 32'h0);
    #1;
    rst = 1'b0;
    txn("rd20r",   1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b0, 32'h1111_2222);

    // Zero wait states, request held high: acks on alternating cycles.
    @(negedge clk);
    cyc0 = 1; stb0 = 1; we0 = 0; adr0 = 32'h4;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b2b_ack", {31'h0, ack0}, {31'h0, (k % 2 == 0)});
      check("b2b_err", {31'h0, err0}, 32'h0);
    end
    cyc0 = 0; stb0 = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
